// File: rtl/moesi_snoop_responder.sv
// MOESI snoop responder: direct-mapped line-state array that answers bus
// snoops (BusRd/BusRdX/BusUpgr) and accepts local fill/update writes.
module moesi_snoop_responder #(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [1:0]        snp_cmd,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_shared,
  output logic              rsp_supply,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              lcl_wr_en,
  input  logic [ADDR_W-1:0] lcl_wr_addr,
  input  logic [2:0]        lcl_wr_state,
  input  logic [DATA_W-1:0] lcl_wr_data,
  input  logic [ADDR_W-1:0] lcl_rd_addr,
  output logic [2:0]        lcl_rd_state,
  output logic [DATA_W-1:0] lcl_rd_data,
  output logic              lcl_rd_hit,
  output logic              lcl_conflict
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

  localparam logic [2:0] ST_I = 3'd0;
  localparam logic [2:0] ST_S = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_O = 3'd3;
  localparam logic [2:0] ST_M = 3'd4;

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_RDX  = 2'b01;
  localparam logic [1:0] CMD_UPGR = 2'b10;
  localparam logic [1:0] CMD_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} fsm_t;

  fsm_t              fsm;
  logic [2:0]        line_state [NUM_LINES];
  logic [TAG_W-1:0]  line_tag   [NUM_LINES];
  logic [DATA_W-1:0] line_data  [NUM_LINES];

  logic [1:0]        req_cmd;
  logic [ADDR_W-3:0] req_addr;
  logic              cmt_en;
  logic [2:0]        cmt_state;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [2:0]        cur_state;
  logic              cur_hit;
  logic              lu_hit, lu_shared, lu_supply, lu_err, lu_commit;
  logic [2:0]        lu_next;

  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [2:0]        wr_state;
  logic              commit_now;
  logic              conflict;

  logic [IDX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]  rd_tag;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{snp_addr[1:0], lcl_wr_addr[1:0], lcl_rd_addr[1:0]};

  assign req_idx = req_addr[IDX_W-1:0];
  assign req_tag = req_addr[ADDR_W-3 -: TAG_W];

  assign wr_idx   = lcl_wr_addr[2 +: IDX_W];
  assign wr_tag   = lcl_wr_addr[ADDR_W-1 -: TAG_W];
  assign wr_state = (lcl_wr_state > ST_M) ? ST_I : lcl_wr_state;

  // Snoop state change lands only on the response handshake edge; it beats a same-index local write
  assign commit_now = (fsm == RESP) && rsp_ready && cmt_en;
  assign conflict   = commit_now && lcl_wr_en && (wr_idx == req_idx);

  // Protocol decision for the captured snoop against the current line
  always_comb begin
    cur_state = line_state[req_idx];
    cur_hit   = (cur_state != ST_I) && (line_tag[req_idx] == req_tag);
    lu_hit    = 1'b0;
    lu_shared = 1'b0;
    lu_supply = 1'b0;
    lu_err    = 1'b0;
    lu_commit = 1'b0;
    lu_next   = cur_state;
    if (req_cmd == CMD_RSVD) begin
      lu_err = 1'b1;
    end else if (cur_hit) begin
      lu_hit = 1'b1;
      case (req_cmd)
        CMD_RD: begin
          lu_shared = 1'b1;
          lu_commit = 1'b1;
          lu_supply = (cur_state == ST_M) || (cur_state == ST_O);
          lu_next   = lu_supply ? ST_O : ST_S;
        end
        CMD_RDX: begin
          lu_commit = 1'b1;
          lu_supply = (cur_state == ST_M) || (cur_state == ST_O);
          lu_next   = ST_I;
        end
        CMD_UPGR: begin
          if ((cur_state == ST_M) || (cur_state == ST_E)) begin
            lu_err = 1'b1;
          end else begin
            lu_commit = 1'b1;
            lu_next   = ST_I;
          end
        end
        default: lu_err = 1'b1;
      endcase
    end
  end

  // Snoop handshake FSM with registered request capture and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      snp_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_shared <= 1'b0;
      rsp_supply <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      req_cmd    <= 2'b00;
      req_addr   <= '0;
      cmt_en     <= 1'b0;
      cmt_state  <= ST_I;
    end else begin
      case (fsm)
        IDLE: begin
          if (snp_valid && snp_ready) begin
            req_cmd   <= snp_cmd;
            req_addr  <= snp_addr[ADDR_W-1:2];
            snp_ready <= 1'b0;
            fsm       <= LOOKUP;
          end
        end
        LOOKUP: begin
          rsp_hit    <= lu_hit;
          rsp_shared <= lu_shared;
          rsp_supply <= lu_supply;
          rsp_err    <= lu_err;
          rsp_data   <= lu_supply ? line_data[req_idx] : '0;
          cmt_en     <= lu_commit;
          cmt_state  <= lu_next;
          rsp_valid  <= 1'b1;
          fsm        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_shared <= 1'b0;
            rsp_supply <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
            cmt_en     <= 1'b0;
            snp_ready  <= 1'b1;
            fsm        <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          snp_ready <= 1'b1;
          fsm       <= IDLE;
        end
      endcase
    end
  end

  // Line array: snoop commit plus local fill/update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        line_state[IDX_W'(i)] <= ST_I;
        line_tag[IDX_W'(i)]   <= '0;
        line_data[IDX_W'(i)]  <= '0;
      end
    end else begin
      if (commit_now) begin
        line_state[req_idx] <= cmt_state;
      end
      if (lcl_wr_en && !conflict) begin
        line_state[wr_idx] <= wr_state;
        line_tag[wr_idx]   <= wr_tag;
        line_data[wr_idx]  <= lcl_wr_data;
      end
    end
  end

  // One-cycle flag for a dropped local write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcl_conflict <= 1'b0;
    end else begin
      lcl_conflict <= conflict;
    end
  end

  assign rd_idx = lcl_rd_addr[2 +: IDX_W];
  assign rd_tag = lcl_rd_addr[ADDR_W-1 -: TAG_W];

  // Combinational local lookup
  always_comb begin
    lcl_rd_hit   = (line_state[rd_idx] != ST_I) && (line_tag[rd_idx] == rd_tag);
    lcl_rd_state = lcl_rd_hit ? line_state[rd_idx] : ST_I;
    lcl_rd_data  = lcl_rd_hit ? line_data[rd_idx] : '0;
  end

endmodule

// File: doc/moesi_snoop_responder.md
MOESI_SNOOP_RESPONDER -- requirements
Module: moesi_snoop_responder

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, meaning the number of direct-mapped lines; it is a power of 2.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the line width (one word per line).
REQ-004 SHALL have port clk  in  1  system clock, all logic on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports snp_valid in 1, snp_ready out 1, snp_cmd in 2 (00 BusRd, 01 BusRdX, 10 BusUpgr, 11 reserved) and snp_addr in ADDR_W, together forming the incoming bus snoop request.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_hit out 1, rsp_shared out 1, rsp_supply out 1, rsp_err out 1 and rsp_data out DATA_W, together forming the snoop response.
REQ-008 SHALL have ports lcl_wr_en in 1, lcl_wr_addr in ADDR_W, lcl_wr_state in 3 and lcl_wr_data in DATA_W, together forming the local controller fill/update port.
REQ-009 SHALL have ports lcl_rd_addr in ADDR_W, lcl_rd_state out 3, lcl_rd_data out DATA_W and lcl_rd_hit out 1, together forming the combinational local lookup.
REQ-010 SHALL have port lcl_conflict  out  1  one-cycle pulse indicating a dropped local write.

Function
REQ-011 SHALL encode states as I=0, S=1, E=2, O=3, M=4; values 5-7 written locally SHALL be stored as I.
REQ-012 SHALL derive index = addr[2 +: log2(NUM_LINES)] and tag = addr[ADDR_W-1 : 2+log2(NUM_LINES)], with addr[1:0] ignored.
REQ-013 SHALL define hit as stored state != I and stored tag == request tag.
REQ-014 SHALL have FSM states IDLE, LOOKUP and RESP; IDLE->LOOKUP on snp_valid&&snp_ready; LOOKUP->RESP unconditionally; RESP->IDLE on rsp_valid&&rsp_ready.
REQ-015 SHALL drive snp_ready=1 only in IDLE; snp_cmd and snp_addr SHALL be captured at acceptance.
REQ-016 SHALL register the response in LOOKUP; rsp_valid=1 only in RESP; with acceptance at cycle T, rsp_valid SHALL be asserted at T+2.
REQ-017 SHALL hold all rsp_* outputs stable while rsp_valid=1 and rsp_ready=0.
REQ-018 SHALL apply BusRd: M->O supply; O->O supply; E->S no supply; S->S no supply; rsp_shared=hit.
REQ-019 SHALL apply BusRdX: M->I supply; O->I supply; E/S->I no supply; rsp_shared=0.
REQ-020 SHALL apply BusUpgr: S/O->I no supply; on M/E hit, rsp_err=1 with no state change.
REQ-021 SHALL, for cmd 11, respond with rsp_err=1, rsp_hit=0 and no state change.
REQ-022 SHALL, on a miss, respond with hit=shared=supply=err=0, no state change and rsp_data=0.
REQ-023 SHALL drive rsp_data = stored data when rsp_supply=1, else 0.
REQ-024 SHALL commit the snoop state update on the clock edge of the rsp handshake, not earlier.
REQ-025 SHALL write state, tag and data on lcl_wr_en at the next edge.
REQ-026 SHALL, when lcl_wr_en coincides with the snoop commit to the same index, let the snoop commit win, drop the local write, and pulse lcl_conflict=1 for one cycle.
REQ-027 SHALL use the stored value for a local write to the snooped index during LOOKUP/RESP (no hazard freeze); the response reflects state at LOOKUP.
REQ-028 SHALL make lcl_rd_* combinational from the current array; lcl_rd_state=I when not hit.

Reset
REQ-029 SHALL, while rst_n=0, force FSM=IDLE, all line states=I, tags/data=0, snp_ready=1, rsp_valid=0, all rsp_* =0 and lcl_conflict=0.
REQ-030 SHALL, on reset mid-transaction, drop that transaction with no state update and no response after release.

Verification
REQ-031 SHALL verify: local write addr 0x40 state M data 0xDEADBEEF; BusRd 0x40 -> rsp at T+2, hit=1, shared=1, supply=1, data=0xDEADBEEF; line becomes O.
REQ-032 SHALL verify: line at 0x80 in E; BusRdX 0x80 -> hit=1, supply=0, data=0; lcl_rd_state=I after handshake.
REQ-033 SHALL verify: line in M; BusUpgr -> rsp_err=1, state remains M; cmd 11 -> rsp_err=1, hit=0.
REQ-034 SHALL verify: BusRd to line in O with rsp_ready low for 5 cycles -> outputs stable, snp_ready=0, state update only at the handshake edge.
REQ-035 SHALL verify: local write to the same index on the handshake edge -> snoop result stored, lcl_conflict pulses 1 cycle.
REQ-036 SHALL verify: rst_n low during RESP -> rsp_valid=0 immediately, all lines I, snp_ready=1 after release.
